// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: serial receiver for the uart transmitter's frames.
//
// A frame is a start bit (0), DATA_BITS data bits sent LSB first, an optional
// parity bit, and one or two stop bits (1). The line is sampled on an
// OVERSAMPLE x baud enable (sample_tick) from the shared baud generator.
//
// Ports
//   clock          system clock
//   rst            synchronous, active-high reset
//   sample_tick    one-clock enable at OVERSAMPLE x baud
//   rx_in          asynchronous serial line, idles high
//   parity_type    00 none, 01 even, 10 odd, 11 none in frame (p_parity_out reported)
//   stop_bits      0 = one stop bit, 1 = two stop bits
//   data_out       last received word, bit 0 = first data bit on the line
//   rx_active      high from start detection to the final stop sample
//   rx_done        one-clock pulse when a frame completes
//   parity_error   parity mismatch on the last frame
//   framing_error  a stop bit sampled low on the last frame
//   p_parity_out   odd-parity bit of data_out when parity_type was 11, else 0
//
// Build option
//   RX_MAJORITY_VOTE_EN  when defined, every bit decision is the 2-of-3 majority
//                        of the sample tick and the two ticks before it, so a
//                        single-tick glitch is rejected. Default: single sample.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for a 1->0 transition of the synchronised line
//   S_START  | counting to mid start bit, rejecting false starts
//   S_DATA   | sampling DATA_BITS data bits, one per bit period
//   S_PARITY | sampling and checking the parity bit
//   S_STOP   | sampling one or two stop bits
//   S_DONE   | one clock; results already registered, rx_done high

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic [1:0]           parity_type,
  input  logic                 stop_bits,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_active,
  output logic                 rx_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 p_parity_out
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [BW-1:0]        bcnt, bcnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_pend, par_pend_nxt;
  logic                 frm_pend, frm_pend_nxt;
  logic                 cfg_capture;
  logic                 frame_end;

  logic                 rx_meta, rx_s, rx_prev;
  logic                 bit_val;
  logic [1:0]           par_q;
  logic                 stop2_q;

  // Two-flop synchroniser; idle level after reset so no spurious start.
  always_ff @(posedge clock) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Line level at the previous tick. Tracked in every state so that after a
  // break the receiver must see the line high before the next start edge.
  always_ff @(posedge clock) begin
    if (rst)              rx_prev <= 1'b1;
    else if (sample_tick) rx_prev <= rx_s;
  end

`ifdef RX_MAJORITY_VOTE_EN
  // hist[0] = line one tick ago, hist[1] = two ticks ago.
  logic [1:0] hist;

  always_ff @(posedge clock) begin
    if (rst)              hist <= 2'b11;
    else if (sample_tick) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Frame configuration is frozen at the start edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      par_q   <= 2'b00;
      stop2_q <= 1'b0;
    end else if (cfg_capture) begin
      par_q   <= parity_type;
      stop2_q <= stop_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      bcnt     <= '0;
      shift    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      bcnt     <= bcnt_nxt;
      shift    <= shift_nxt;
      par_pend <= par_pend_nxt;
      frm_pend <= frm_pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tcnt_nxt     = tcnt;
    bcnt_nxt     = bcnt;
    shift_nxt    = shift;
    par_pend_nxt = par_pend;
    frm_pend_nxt = frm_pend;
    cfg_capture  = 1'b0;
    frame_end    = 1'b0;

    case (state)
      S_IDLE: begin
        if (sample_tick && rx_prev && !rx_s) begin
          state_nxt    = S_START;
          tcnt_nxt     = '0;
          cfg_capture  = 1'b1;
          par_pend_nxt = 1'b0;
          frm_pend_nxt = 1'b0;
        end
      end

      S_START: begin
        if (sample_tick) begin
          if (tcnt == T_MID) begin
            if (bit_val) begin
              state_nxt = S_IDLE;
            end else begin
              // Re-zero at mid start bit so later samples land mid-bit.
              tcnt_nxt  = '0;
              bcnt_nxt  = '0;
              state_nxt = S_DATA;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (sample_tick) begin
          if (tcnt == T_END) begin
            tcnt_nxt  = '0;
            shift_nxt = {bit_val, shift[DATA_BITS-1:1]};
            if (bcnt == B_LAST) begin
              bcnt_nxt  = '0;
              state_nxt = (par_q == 2'b01 || par_q == 2'b10) ? S_PARITY : S_STOP;
            end else begin
              bcnt_nxt = bcnt + 1'b1;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (sample_tick) begin
          if (tcnt == T_END) begin
            tcnt_nxt = '0;
            if (par_q == 2'b01) par_pend_nxt = (bit_val != (^shift));
            else                par_pend_nxt = (bit_val != (~^shift));
            state_nxt = S_STOP;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (sample_tick) begin
          if (tcnt == T_END) begin
            tcnt_nxt = '0;
            if (!bit_val) frm_pend_nxt = 1'b1;
            if (stop2_q && bcnt == '0) begin
              bcnt_nxt = BW'(1);
            end else begin
              bcnt_nxt  = '0;
              frame_end = 1'b1;
              state_nxt = S_DONE;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Results load on the final stop sample so they are valid in the same clock
  // as rx_done (the S_DONE clock), and hold until the next frame completes.
  always_ff @(posedge clock) begin
    if (rst) begin
      data_out      <= '0;
      rx_done       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      p_parity_out  <= 1'b0;
    end else begin
      rx_done <= frame_end;
      if (frame_end) begin
        data_out      <= shift;
        parity_error  <= par_pend;
        framing_error <= frm_pend_nxt;
        p_parity_out  <= (par_q == 2'b11) ? (~^shift) : 1'b0;
      end
    end
  end

  assign rx_active = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clock;
  logic       rst;
  logic       sample_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       framing_error;
  logic       p_parity_out;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int tick_idx = 0;
  int done_tick = 0;
  int t0, t1;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock         (clock),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx_in         (rx_in),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .data_out      (data_out),
    .rx_active     (rx_active),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .p_parity_out  (p_parity_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One sample_tick every 4 clocks.
  initial begin
    int div;
    div = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clock);
      div = (div + 1) % 4;
      sample_tick = (div == 0);
      if (sample_tick) tick_idx++;
    end
  end

  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      done_tick = tick_idx;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (!sample_tick) @(posedge clock);
    end
  endtask

  task automatic set_line(input logic v);
    @(negedge clock);
    rx_in = v;
  endtask

  // One bit period; optionally inverts the line for a single tick mid-bit.
  task automatic send_bit(input logic v, input bit glitch);
    set_line(v);
    if (glitch) begin
      wait_ticks(8);
      set_line(~v);
      wait_ticks(1);
      set_line(v);
      wait_ticks(7);
    end else begin
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pbit,
                            input int nstop, input logic stop2_val, input int glitch_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], (glitch_bit == i));
    if (has_par) send_bit(pbit, 1'b0);
    send_bit(1'b1, 1'b0);
    if (nstop == 2) send_bit(stop2_val, 1'b0);
  endtask

  task automatic idle_ticks(input int n);
    set_line(1'b1);
    wait_ticks(n);
    @(negedge clock);
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    parity_type = 2'b00;
    stop_bits = 1'b0;
    repeat (5) @(negedge clock);
    chk("reset_data", data_out, 8'h00);
    chk("reset_active", rx_active, 1'b0);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_perr", parity_error, 1'b0);
    chk("reset_ferr", framing_error, 1'b0);
    chk("reset_ppar", p_parity_out, 1'b0);
    rst = 1'b0;
    idle_ticks(8);

    // Preload a byte so the mid-frame reset visibly clears data_out.
    send_frame(8'h96, 0, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("pre_data", data_out, 8'h96);
    chk("pre_done", done_cnt, exp_done);

    // Reset in the middle of data bit 4.
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    set_line(1'b1);
    wait_ticks(8);
    @(negedge clock);
    chk("mid_active", rx_active, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstmid_active", rx_active, 1'b0);
    chk("rstmid_data", data_out, 8'h00);
    chk("rstmid_done_out", rx_done, 1'b0);
    rst = 1'b0;
    idle_ticks(32);
    chk("rstmid_no_done", done_cnt, exp_done);

    send_frame(8'h3C, 0, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("clean_data", data_out, 8'h3C);
    chk("clean_done", done_cnt, exp_done);

    // Even parity.
    parity_type = 2'b01;
    send_frame(8'hA5, 1, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("even_ok_data", data_out, 8'hA5);
    chk("even_ok_perr", parity_error, 1'b0);
    chk("even_ok_done", done_cnt, exp_done);
    send_frame(8'hA5, 1, 1'b1, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("even_bad_data", data_out, 8'hA5);
    chk("even_bad_perr", parity_error, 1'b1);
    chk("even_bad_done", done_cnt, exp_done);

    // Two stop bits, second one low.
    parity_type = 2'b00;
    stop_bits = 1'b1;
    send_frame(8'h81, 0, 1'b0, 2, 1'b0, -1);
    idle_ticks(4);
    exp_done++;
    chk("stop2_data", data_out, 8'h81);
    chk("stop2_ferr", framing_error, 1'b1);
    chk("stop2_perr_clr", parity_error, 1'b0);
    chk("stop2_done", done_cnt, exp_done);
    send_frame(8'h55, 0, 1'b0, 2, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("stop2ok_data", data_out, 8'h55);
    chk("stop2ok_ferr", framing_error, 1'b0);
    chk("stop2ok_done", done_cnt, exp_done);

    // Three-tick low glitch on an idle line: false start.
    stop_bits = 1'b0;
    set_line(1'b0);
    wait_ticks(3);
    @(negedge clock);
    chk("glitch_active", rx_active, 1'b1);
    set_line(1'b1);
    wait_ticks(16);
    @(negedge clock);
    chk("glitch_idle", rx_active, 1'b0);
    chk("glitch_no_done", done_cnt, exp_done);

`ifdef RX_MAJORITY_VOTE_EN
    send_frame(8'hF0, 0, 1'b0, 1, 1'b1, 0);
    idle_ticks(4);
    exp_done++;
    chk("vote_data", data_out, 8'hF0);
    chk("vote_done", done_cnt, exp_done);
`endif

    // Back-to-back frames, odd parity.
    parity_type = 2'b10;
    send_frame(8'h12, 1, 1'b1, 1, 1'b1, -1);
    @(negedge clock);
    exp_done++;
    chk("b2b1_data", data_out, 8'h12);
    chk("b2b1_perr", parity_error, 1'b0);
    chk("b2b1_done", done_cnt, exp_done);
    t1 = done_tick;
    send_frame(8'hEF, 1, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("b2b2_data", data_out, 8'hEF);
    chk("b2b2_perr", parity_error, 1'b0);
    chk("b2b2_done", done_cnt, exp_done);
    chk("b2b_gap", ((done_tick - t1) >= 160) && ((done_tick - t1) <= 180), 1'b1);

    // parity_type 11: no parity bit in the frame, p_parity_out reported.
    parity_type = 2'b11;
    t0 = tick_idx;
    send_frame(8'h07, 0, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("p11_data", data_out, 8'h07);
    chk("p11_ppar", p_parity_out, 1'b0);
    chk("p11_perr", parity_error, 1'b0);
    chk("p11_done", done_cnt, exp_done);
    chk("p11_len", ((done_tick - t0) >= 150) && ((done_tick - t0) <= 158), 1'b1);
    send_frame(8'h03, 0, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("p11b_data", data_out, 8'h03);
    chk("p11b_ppar", p_parity_out, 1'b1);

    // Break: line low for 30 bit times.
    set_line(1'b0);
    wait_ticks(480);
    @(negedge clock);
    exp_done++;
    chk("brk_done", done_cnt, exp_done);
    chk("brk_data", data_out, 8'h00);
    chk("brk_ferr", framing_error, 1'b1);
    chk("brk_ppar", p_parity_out, 1'b1);
    chk("brk_active", rx_active, 1'b0);
    idle_ticks(32);
    chk("brk_no_dup", done_cnt, exp_done);
    send_frame(8'h5A, 0, 1'b0, 1, 1'b1, -1);
    idle_ticks(4);
    exp_done++;
    chk("after_brk_data", data_out, 8'h5A);
    chk("after_brk_ferr", framing_error, 1'b0);
    chk("after_brk_ppar", p_parity_out, 1'b1);
    chk("after_brk_done", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
